// File: rtl/sargantana_itag_ctrl.sv
// Sequencer/arbiter for the I-cache tag array: arbitrates invalidate > fill > lookup on the single tag port
// and turns the returned per-way tags into a one-hot hit response. Optional macro: ITAG_CTRL_PERF_CNT_EN.
module sargantana_itag_ctrl #(
   parameter int ICACHE_N_WAY   = 4,
   parameter int TAG_DEPTH      = 64,
   parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
   parameter int TAG_WIDHT      = 20,
   parameter int WAY_W          = $clog2(ICACHE_N_WAY)
) (
   input  logic                              clk_i,
   input  logic                              rstn_i,
   input  logic                              lkp_valid_i,
   output logic                              lkp_ready_o,
   input  logic [TAG_ADDR_WIDHT-1:0]         lkp_idx_i,
   input  logic [TAG_WIDHT-1:0]              lkp_tag_i,
   output logic                              rsp_valid_o,
   output logic                              rsp_hit_o,
   output logic [ICACHE_N_WAY-1:0]           rsp_way_o,
   output logic                              rsp_multihit_o,
   input  logic                              fill_valid_i,
   output logic                              fill_ready_o,
   input  logic [TAG_ADDR_WIDHT-1:0]         fill_idx_i,
   input  logic [TAG_WIDHT-1:0]              fill_tag_i,
   input  logic [WAY_W-1:0]                  fill_way_i,
   input  logic                              inval_i,
   output logic                              busy_o,
   output logic [ICACHE_N_WAY-1:0]           tm_req_o,
   output logic                              tm_we_o,
   output logic                              tm_vbit_o,
   output logic                              tm_flush_o,
   output logic [TAG_ADDR_WIDHT-1:0]         tm_addr_o,
   output logic [TAG_WIDHT-1:0]              tm_data_o,
   input  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tm_tag_way_i,
   input  logic [ICACHE_N_WAY-1:0]           tm_vbit_i
`ifdef ITAG_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]                       perf_hit_o,
   output logic [31:0]                       perf_miss_o
`endif
);

   localparam int CNT_W = WAY_W + 1;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic                      invalPend_q, invalPend_d;
   logic                      flushCmd;
   logic                      runReady;
   logic                      fillFire;
   logic                      lkpFire;
   logic [ICACHE_N_WAY-1:0]   wayOneHot;
   logic [TAG_ADDR_WIDHT-1:0] addr_q;
   logic [TAG_WIDHT-1:0]      data_q;
   logic                      rspValid_q;
   logic [TAG_WIDHT-1:0]      tag_q;
   logic [ICACHE_N_WAY-1:0]   hitVec;
   logic [CNT_W-1:0]          hitCnt;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= ST_INIT;
         invalPend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         invalPend_q <= invalPend_d;
      end
   end

   // A pulse seen while FLUSH is running must survive the clear so it buys one more FLUSH.
   always_comb begin
      state_d     = state_q;
      invalPend_d = invalPend_q | inval_i;
      flushCmd    = 1'b0;
      case (state_q)
         ST_INIT: begin
            flushCmd = 1'b1;
            state_d  = ST_RUN;
         end
         ST_FLUSH: begin
            flushCmd    = 1'b1;
            invalPend_d = inval_i;
            state_d     = ST_RUN;
         end
         ST_RUN: begin
            if (inval_i || invalPend_q) begin
               state_d = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   assign runReady     = (state_q == ST_RUN) && !invalPend_q && !inval_i;
   assign fill_ready_o = runReady;
   assign lkp_ready_o  = runReady && !fill_valid_i;
   assign fillFire     = fill_valid_i && runReady;
   assign lkpFire      = lkp_valid_i && lkp_ready_o;
   assign busy_o       = (state_q != ST_RUN) || invalPend_q;

   // INIT is the reset state, so the flush strobe is held off while reset is still asserted.
   assign tm_flush_o   = flushCmd && rstn_i;

   always_comb begin
      wayOneHot             = '0;
      wayOneHot[fill_way_i] = 1'b1;
   end

   always_comb begin
      tm_req_o  = '0;
      tm_we_o   = 1'b0;
      tm_vbit_o = 1'b0;
      tm_addr_o = addr_q;
      tm_data_o = data_q;
      if (fillFire) begin
         tm_req_o  = wayOneHot;
         tm_we_o   = 1'b1;
         tm_vbit_o = 1'b1;
         tm_addr_o = fill_idx_i;
         tm_data_o = fill_tag_i;
      end else if (lkpFire) begin
         tm_req_o  = '1;
         tm_addr_o = lkp_idx_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         addr_q     <= '0;
         data_q     <= '0;
         rspValid_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         addr_q     <= tm_addr_o;
         data_q     <= tm_data_o;
         rspValid_q <= lkpFire;
         if (lkpFire) begin
            tag_q <= lkp_tag_i;
         end
      end
   end

   // The array returns registered read data, so compare happens in the cycle after the request.
   always_comb begin
      hitVec = '0;
      hitCnt = '0;
      for (int i = 0; i < ICACHE_N_WAY; i++) begin
         hitVec[i] = tm_vbit_i[i] && (tm_tag_way_i[i*TAG_WIDHT +: TAG_WIDHT] == tag_q);
         hitCnt    = hitCnt + CNT_W'(hitVec[i]);
      end
   end

   assign rsp_valid_o    = rspValid_q;
   assign rsp_way_o      = rspValid_q ? hitVec : '0;
   assign rsp_hit_o      = |rsp_way_o;
   assign rsp_multihit_o = rspValid_q && (hitCnt > CNT_W'(1));

`ifdef ITAG_CTRL_PERF_CNT_EN
   logic [31:0] perfHit_q;
   logic [31:0] perfMiss_q;

   // Saturating counters; only reset clears them, invalidate leaves them alone.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         perfHit_q  <= '0;
         perfMiss_q <= '0;
      end else if (rspValid_q) begin
         if (rsp_hit_o) begin
            if (perfHit_q != 32'hFFFF_FFFF) begin
               perfHit_q <= perfHit_q + 32'd1;
            end
         end else begin
            if (perfMiss_q != 32'hFFFF_FFFF) begin
               perfMiss_q <= perfMiss_q + 32'd1;
            end
         end
      end
   end

   assign perf_hit_o  = perfHit_q;
   assign perf_miss_o = perfMiss_q;
`else
   // Without the counters the response path carries no extra state.
`endif

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Self-checking bench for sargantana_itag_ctrl: a behavioural tag-array environment answers the DUT,
// while a set-content model and an unavailability-window model predict every output each cycle.
module tb_sargantana_itag_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        lkp_valid;
   logic        lkp_ready;
   logic [5:0]  lkp_idx;
   logic [19:0] lkp_tag;
   logic        rsp_valid;
   logic        rsp_hit;
   logic [3:0]  rsp_way;
   logic        rsp_multihit;
   logic        fill_valid;
   logic        fill_ready;
   logic [5:0]  fill_idx;
   logic [19:0] fill_tag;
   logic [1:0]  fill_way;
   logic        inval;
   logic        busy;
   logic [3:0]  tm_req;
   logic        tm_we;
   logic        tm_vbit;
   logic        tm_flush;
   logic [5:0]  tm_addr;
   logic [19:0] tm_data;
   logic [79:0] tm_tag_way;
   logic [3:0]  tm_vbit_rd;
`ifdef ITAG_CTRL_PERF_CNT_EN
   logic [31:0] perf_hit;
   logic [31:0] perf_miss;
`endif

   int          checks   = 0;
   int          failures = 0;

   // Behavioural tag SRAM seen by the DUT; seeded with valid garbage so missing flushes show up.
   logic        seedMem = 1'b0;
   logic [19:0] memTag [4][64];
   logic        memVld [4][64];

   // Reference state: what the cache should contain, and when the block should be unavailable.
   logic [19:0] refTag [64][4];
   bit          refVld [64][4];
   int          unavail;
   bit          pendValid;
   logic [3:0]  pendWay;
   logic [5:0]  lastAddr;
   logic [19:0] lastData;
   logic [31:0] expPerfHit;
   logic [31:0] expPerfMiss;

   always #5 clk = ~clk;

   sargantana_itag_ctrl dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .lkp_valid_i    (lkp_valid),
      .lkp_ready_o    (lkp_ready),
      .lkp_idx_i      (lkp_idx),
      .lkp_tag_i      (lkp_tag),
      .rsp_valid_o    (rsp_valid),
      .rsp_hit_o      (rsp_hit),
      .rsp_way_o      (rsp_way),
      .rsp_multihit_o (rsp_multihit),
      .fill_valid_i   (fill_valid),
      .fill_ready_o   (fill_ready),
      .fill_idx_i     (fill_idx),
      .fill_tag_i     (fill_tag),
      .fill_way_i     (fill_way),
      .inval_i        (inval),
      .busy_o         (busy),
      .tm_req_o       (tm_req),
      .tm_we_o        (tm_we),
      .tm_vbit_o      (tm_vbit),
      .tm_flush_o     (tm_flush),
      .tm_addr_o      (tm_addr),
      .tm_data_o      (tm_data),
      .tm_tag_way_i   (tm_tag_way),
      .tm_vbit_i      (tm_vbit_rd)
`ifdef ITAG_CTRL_PERF_CNT_EN
      ,
      .perf_hit_o     (perf_hit),
      .perf_miss_o    (perf_miss)
`endif
   );

   always @(posedge clk) begin
      if (seedMem) begin
         for (int w = 0; w < 4; w++) begin
            for (int s = 0; s < 64; s++) begin
               memTag[w][s] <= 20'hABCDE;
               memVld[w][s] <= 1'b1;
            end
         end
         tm_tag_way <= '0;
         tm_vbit_rd <= '0;
      end else begin
         if (tm_flush) begin
            for (int w = 0; w < 4; w++) begin
               for (int s = 0; s < 64; s++) begin
                  memVld[w][s] <= 1'b0;
               end
            end
         end
         for (int w = 0; w < 4; w++) begin
            if (tm_req[w] && tm_we) begin
               memTag[w][tm_addr] <= tm_data;
               memVld[w][tm_addr] <= tm_vbit;
            end
            if (tm_req[w] && !tm_we) begin
               tm_tag_way[w*20 +: 20] <= memTag[w][tm_addr];
               tm_vbit_rd[w]          <= memVld[w][tm_addr];
            end
         end
      end
   end

   task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearModel();
      for (int s = 0; s < 64; s++) begin
         for (int w = 0; w < 4; w++) begin
            refVld[s][w] = 1'b0;
            refTag[s][w] = '0;
         end
      end
   endtask

   // Samples at the falling edge, predicts this cycle's outputs, then advances the model.
   task automatic checkOutput();
      bit         avail;
      bit         fillFire;
      bit         lkpFire;
      logic [3:0] expReq;
      logic [5:0] expAddr;
      logic [19:0] expData;
      logic [3:0] newWay;
      @(negedge clk);
      avail    = (unavail == 0) && !inval;
      fillFire = fill_valid && avail;
      lkpFire  = lkp_valid && avail && !fill_valid;
      expReq   = 4'h0;
      expAddr  = lastAddr;
      expData  = lastData;
      if (fillFire) begin
         expReq  = 4'h1 << fill_way;
         expAddr = fill_idx;
         expData = fill_tag;
      end else if (lkpFire) begin
         expReq  = 4'hF;
         expAddr = lkp_idx;
      end
      compareValue("busy", busy, unavail != 0);
      compareValue("tm_flush", tm_flush, unavail == 1);
      compareValue("fill_ready", fill_ready, avail);
      compareValue("lkp_ready", lkp_ready, avail && !fill_valid);
      compareValue("tm_req", tm_req, expReq);
      compareValue("tm_we", tm_we, fillFire);
      compareValue("tm_vbit", tm_vbit, fillFire);
      compareValue("tm_addr", tm_addr, expAddr);
      compareValue("tm_data", tm_data, expData);
      compareValue("rsp_valid", rsp_valid, pendValid);
`ifdef ITAG_CTRL_PERF_CNT_EN
      compareValue("perf_hit", perf_hit, expPerfHit);
      compareValue("perf_miss", perf_miss, expPerfMiss);
`endif
      if (pendValid) begin
         compareValue("rsp_way", rsp_way, pendWay);
         compareValue("rsp_hit", rsp_hit, pendWay != 4'h0);
         compareValue("rsp_multihit", rsp_multihit, $countones(pendWay) > 1);
         if (pendWay != 4'h0) expPerfHit++;
         else expPerfMiss++;
      end
      lastAddr = expAddr;
      lastData = expData;
      if (fillFire) begin
         refTag[fill_idx][fill_way] = fill_tag;
         refVld[fill_idx][fill_way] = 1'b1;
      end
      newWay = 4'h0;
      if (lkpFire) begin
         for (int w = 0; w < 4; w++) begin
            newWay[w] = refVld[lkp_idx][w] && (refTag[lkp_idx][w] == lkp_tag);
         end
      end
      pendValid = lkpFire;
      pendWay   = newWay;
      if (inval) begin
         clearModel();
         unavail = (unavail == 0) ? 1 : unavail + 1;
      end else if (unavail > 0) begin
         unavail--;
      end
   endtask

   task automatic applyStimulus(input logic fv, input logic [5:0] fidx, input logic [19:0] ftag,
                                input logic [1:0] fway, input logic lv, input logic [5:0] lidx,
                                input logic [19:0] ltag, input logic inv);
      fill_valid = fv;
      fill_idx   = fidx;
      fill_tag   = ftag;
      fill_way   = fway;
      lkp_valid  = lv;
      lkp_idx    = lidx;
      lkp_tag    = ltag;
      inval      = inv;
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b0, 6'd0, 20'h0, 1'b0);
      end
   endtask

   task automatic doReset();
      rstn       = 1'b0;
      fill_valid = 1'b0;
      fill_idx   = '0;
      fill_tag   = '0;
      fill_way   = '0;
      lkp_valid  = 1'b0;
      lkp_idx    = '0;
      lkp_tag    = '0;
      inval      = 1'b0;
      seedMem    = 1'b1;
      @(posedge clk);
      #1;
      seedMem = 1'b0;
      compareValue("rst_busy", busy, 1);
      compareValue("rst_tm_flush", tm_flush, 0);
      compareValue("rst_rsp_valid", rsp_valid, 0);
      compareValue("rst_tm_req", tm_req, 0);
      compareValue("rst_lkp_ready", lkp_ready, 0);
      compareValue("rst_tm_addr", tm_addr, 0);
      @(posedge clk);
      #1;
      rstn        = 1'b1;
      unavail     = 1;
      pendValid   = 1'b0;
      pendWay     = 4'h0;
      lastAddr    = '0;
      lastData    = '0;
      expPerfHit  = '0;
      expPerfMiss = '0;
      clearModel();
   endtask

   function automatic logic [19:0] pickTag();
      case ($urandom_range(0, 3))
         0:       return 20'hABCDE;
         1:       return 20'h12345;
         2:       return 20'h5A5A5;
         default: return 20'h00001;
      endcase
   endfunction

   initial begin
      logic       fv;
      logic       lv;
      logic       inv;
      doReset();

      $display("[TB] post-reset init flush");
      idle(2);

      $display("[TB] fill then hit / miss / back-to-back lookups");
      applyStimulus(1'b1, 6'd5, 20'hABCDE, 2'd2, 1'b0, 6'd0, 20'h0, 1'b0);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd5, 20'hABCDE, 1'b0);
      compareValue("hit_way_0100", rsp_way, 4'b0100);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd5, 20'h12345, 1'b0);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd5, 20'hABCDE, 1'b0);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd6, 20'hABCDE, 1'b0);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd5, 20'hABCDE, 1'b0);
      idle(1);

      $display("[TB] fill wins over lookup, write-before-read");
      applyStimulus(1'b1, 6'd7, 20'h11111, 2'd1, 1'b1, 6'd5, 20'hABCDE, 1'b0);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd5, 20'hABCDE, 1'b0);
      applyStimulus(1'b1, 6'd12, 20'h77777, 2'd3, 1'b0, 6'd0, 20'h0, 1'b0);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd12, 20'h77777, 1'b0);
      idle(1);

      $display("[TB] invalidate during fill burst");
      applyStimulus(1'b1, 6'd20, 20'h22222, 2'd0, 1'b0, 6'd0, 20'h0, 1'b0);
      applyStimulus(1'b1, 6'd21, 20'h22222, 2'd1, 1'b1, 6'd5, 20'hABCDE, 1'b1);
      applyStimulus(1'b1, 6'd22, 20'h22222, 2'd2, 1'b1, 6'd5, 20'hABCDE, 1'b0);
      applyStimulus(1'b1, 6'd23, 20'h22222, 2'd3, 1'b0, 6'd0, 20'h0, 1'b0);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd5, 20'hABCDE, 1'b0);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd20, 20'h22222, 1'b0);
      idle(1);

      $display("[TB] multihit");
      applyStimulus(1'b1, 6'd9, 20'h5A5A5, 2'd0, 1'b0, 6'd0, 20'h0, 1'b0);
      applyStimulus(1'b1, 6'd9, 20'h5A5A5, 2'd1, 1'b0, 6'd0, 20'h0, 1'b0);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd9, 20'h5A5A5, 1'b0);
      compareValue("multihit_flag", rsp_multihit, 1);
      idle(2);

      $display("[TB] invalidate arriving during flush");
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b0, 6'd0, 20'h0, 1'b1);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b0, 6'd0, 20'h0, 1'b1);
      idle(4);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         fv  = ($urandom_range(0, 2) == 0);
         lv  = ($urandom_range(0, 1) == 0);
         inv = ($urandom_range(0, 40) == 0) && (unavail != 2);
         applyStimulus(fv, 6'($urandom_range(0, 7)), pickTag(), 2'($urandom_range(0, 3)),
                       lv, 6'($urandom_range(0, 7)), pickTag(), inv);
      end
      idle(3);

      $display("[TB] reset with a response in flight");
      applyStimulus(1'b1, 6'd9, 20'h5A5A5, 2'd3, 1'b0, 6'd0, 20'h0, 1'b0);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd9, 20'h5A5A5, 1'b0);
      rstn = 1'b0;
      #1;
      compareValue("midrst_rsp_valid", rsp_valid, 0);
      compareValue("midrst_busy", busy, 1);
      doReset();
      idle(2);
      applyStimulus(1'b0, 6'd0, 20'h0, 2'd0, 1'b1, 6'd9, 20'h5A5A5, 1'b0);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
